// File: rtl/pl_mips_defines.sv
// Shared ALU control codes, mul/div FSM state type and opcode helpers for the
// MIPS execute stage.
package pl_mips_defines;

  localparam logic [3:0] ALU_CTRL_AND   = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR    = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD   = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB   = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT   = 4'b0111;
  localparam logic [3:0] ALU_CTRL_MULT  = 4'b1000;
  localparam logic [3:0] ALU_CTRL_MULTU = 4'b1001;
  localparam logic [3:0] ALU_CTRL_DIV   = 4'b1010;
  localparam logic [3:0] ALU_CTRL_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_CTRL_MFHI  = 4'b1100;
  localparam logic [3:0] ALU_CTRL_MFLO  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [3:0] ctrl);
    return (ctrl == ALU_CTRL_MULT) || (ctrl == ALU_CTRL_MULTU) ||
           (ctrl == ALU_CTRL_DIV)  || (ctrl == ALU_CTRL_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] ctrl);
    return (ctrl == ALU_CTRL_DIV) || (ctrl == ALU_CTRL_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] ctrl);
    return (ctrl == ALU_CTRL_MULT) || (ctrl == ALU_CTRL_DIV);
  endfunction

  // Any instruction that reads or writes HI/LO must wait for the engine.
  function automatic logic uses_hilo(input logic [3:0] ctrl);
    return is_muldiv(ctrl) || (ctrl == ALU_CTRL_MFHI) || (ctrl == ALU_CTRL_MFLO);
  endfunction

endpackage

// File: rtl/pl_alu_md_if.sv
// Operand/result bundle between the EX stage control and the ALU.
interface pl_alu_md_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [3:0]       alu_control;
  logic             start;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op1, op2, alu_control, start,
    input  res, zero, overflow, busy, done, stall, hi, lo
  );

  modport slave (
    input  op1, op2, alu_control, start,
    output res, zero, overflow, busy, done, stall, hi, lo
  );
endinterface

// File: rtl/pl_muldiv_core.sv
// Iterative multiply / restoring divide engine owning the HI/LO registers.
// Works on magnitudes; signs are reapplied in the FIX state.
module pl_muldiv_core
  import pl_mips_defines::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_div_q, is_div_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    work_d    = work_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sum       = '0;
    shifted   = '0;
    ge        = 1'b0;
    prod      = '0;

    sa    = is_signed_op(op) & a[WIDTH-1];
    sb    = is_signed_op(op) & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;

    case (state_q)
      IDLE: begin
        if (start && is_muldiv(op)) begin
          // Mul: opnd = multiplicand, work = multiplier.
          // Div: opnd = divisor, work = dividend shifting out / quotient shifting in.
          opnd_d    = is_div_op(op) ? mag_b : mag_a;
          work_d    = is_div_op(op) ? mag_a : mag_b;
          acc_d     = '0;
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          is_div_d  = is_div_op(op);
          div0_d    = (b == '0);
          cnt_d     = CW'(WIDTH);
          state_d   = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
        if (is_div_q) begin
          shifted = {acc_q, work_q[WIDTH-1]};
          ge      = (shifted >= {1'b0, opnd_q});
          acc_d   = ge ? (shifted[WIDTH-1:0] - opnd_q) : shifted[WIDTH-1:0];
          work_d  = {work_q[WIDTH-2:0], ge};
        end else begin
          sum    = {1'b0, acc_q} + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
          acc_d  = sum[WIDTH:1];
          work_d = {sum[0], work_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        prod = neg_q ? -{acc_q, work_q} : {acc_q, work_q};
        if (is_div_q) begin
          // A zero divisor leaves the dividend in acc, so only the quotient needs forcing.
          lo_d = div0_q ? {WIDTH{1'b1}} : (neg_q ? -work_q : work_q);
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      work_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: rtl/pl_alu_md.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, HI/LO reads and the
// hazard stall request, with the iterative mul/div engine underneath.
module pl_alu_md
  import pl_mips_defines::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pl_alu_md_if.slave  bus
);
  logic [WIDTH-1:0] hi_w, lo_w;
  logic             busy_w, done_w;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  pl_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.start),
    .op    (bus.alu_control),
    .a     (bus.op1),
    .b     (bus.op2),
    .hi    (hi_w),
    .lo    (lo_w),
    .busy  (busy_w),
    .done  (done_w)
  );

  assign add_res = bus.op1 + bus.op2;
  assign sub_res = bus.op1 - bus.op2;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (bus.alu_control)
      ALU_CTRL_AND: res_c = bus.op1 & bus.op2;
      ALU_CTRL_OR:  res_c = bus.op1 | bus.op2;
      ALU_CTRL_ADD: begin
        res_c = add_res;
        ovf_c = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                (add_res[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      ALU_CTRL_SUB: begin
        res_c = sub_res;
        ovf_c = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                (sub_res[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      ALU_CTRL_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      ALU_CTRL_MFHI: res_c = hi_w;
      ALU_CTRL_MFLO: res_c = lo_w;
      default:       res_c = '0;
    endcase
  end

  assign bus.res      = res_c;
  assign bus.zero     = (res_c == '0);
  assign bus.overflow = ovf_c;
  assign bus.busy     = busy_w;
  assign bus.done     = done_w;
  assign bus.stall    = busy_w && uses_hilo(bus.alu_control) && bus.start;
  assign bus.hi       = hi_w;
  assign bus.lo       = lo_w;

endmodule

// File: tb/tb_pl_alu_md.sv
// Scoreboard bench for pl_alu_md: stimulus pushes expectations, a negedge
// monitor pops and compares combinational probes and mul/div completions.
module tb_pl_alu_md;
  import pl_mips_defines::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        stall;
    logic        busy;
    logic        chk_hl;
    logic [31:0] hi;
    logic [31:0] lo;
  } probe_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          issue;
  } md_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   busy_cnt;
  bit   probe_en;
  probe_t pq[$];
  md_t    mq[$];

  pl_alu_md_if #(.WIDTH(32)) bus ();

  pl_alu_md #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  always @(negedge clk) begin
    md_t    m;
    probe_t p;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (mq.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_done: got done=1 required no pulse (cycle %0d)", cyc);
        end else begin
          m = mq.pop_front();
          chk({m.name, "_hi"}, bus.hi, m.hi);
          chk({m.name, "_lo"}, bus.lo, m.lo);
          chk({m.name, "_latency"}, 32'(cyc - m.issue), 32'd34);
          chk({m.name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        end
        busy_cnt = 0;
      end
    end
    if (probe_en) begin
      if (pq.size() == 0) begin
        n_chk++;
        $display("FAIL probe_queue: got empty queue required an expectation (cycle %0d)", cyc);
      end else begin
        p = pq.pop_front();
        chk({p.name, "_res"}, bus.res, p.res);
        chk({p.name, "_zero"}, 32'(bus.zero), 32'(p.zero));
        chk({p.name, "_ovf"}, 32'(bus.overflow), 32'(p.ovf));
        chk({p.name, "_stall"}, 32'(bus.stall), 32'(p.stall));
        chk({p.name, "_busy"}, 32'(bus.busy), 32'(p.busy));
        if (p.chk_hl) begin
          chk({p.name, "_hi"}, bus.hi, p.hi);
          chk({p.name, "_lo"}, bus.lo, p.lo);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic st);
    bus.alu_control = c;
    bus.op1         = a;
    bus.op2         = b;
    bus.start       = st;
  endtask

  task automatic probe(input string nm, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic st, input logic [31:0] r,
                       input logic z, input logic o, input logic s, input logic bz,
                       input logic hl, input logic [31:0] eh, input logic [31:0] el);
    probe_t p;
    p.name = nm; p.res = r; p.zero = z; p.ovf = o; p.stall = s; p.busy = bz;
    p.chk_hl = hl; p.hi = eh; p.lo = el;
    drive(c, a, b, st);
    pq.push_back(p);
    probe_en = 1'b1;
    @(posedge clk);
    #1;
    probe_en = 1'b0;
  endtask

  task automatic push_md(input string nm, input logic [31:0] eh, input logic [31:0] el);
    md_t m;
    m.name = nm; m.hi = eh; m.lo = el; m.issue = cyc;
    mq.push_back(m);
  endtask

  task automatic issue(input string nm, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    drive(c, a, b, 1'b1);
    push_md(nm, eh, el);
    @(posedge clk);
    #1;
    drive(ALU_CTRL_AND, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && mq.size() > 0; i++) @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      n_chk++;
      $display("FAIL md_timeout: got %0d pending results required 0 (cycle %0d)", mq.size(), cyc);
      mq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; busy_cnt = 0; probe_en = 1'b0;
    rst_n = 1'b0;
    drive(ALU_CTRL_AND, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    probe("reset", ALU_CTRL_AND, 32'h0, 32'h0, 1'b0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 32'h0);
    probe("add_ovf", ALU_CTRL_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 0, 1, 0, 0, 0, 0, 0);
    probe("sub_zero", ALU_CTRL_SUB, 32'd5, 32'd5, 1'b1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    probe("slt_neg", ALU_CTRL_SLT, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    probe("slt_pos", ALU_CTRL_SLT, 32'h1, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    probe("and", ALU_CTRL_AND, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'h00F01200, 0, 0, 0, 0, 0, 0, 0);
    probe("or", ALU_CTRL_OR, 32'hF0F01234, 32'h0FF0FF00, 1'b1, 32'hFFF0FF34, 0, 0, 0, 0, 0, 0, 0);
    probe("sub_ovf", ALU_CTRL_SUB, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 0, 1, 0, 0, 0, 0, 0);
    probe("add_wrap", ALU_CTRL_ADD, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    probe("mult_res0", ALU_CTRL_MULT, 32'h5, 32'h3, 1'b0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    probe("unused_code", 4'b1111, 32'h5, 32'h3, 1'b1, 32'h0, 1, 0, 0, 0, 0, 0, 0);

    issue("mult_neg", ALU_CTRL_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    drain();
    issue("multu", ALU_CTRL_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    drain();
    issue("div_neg", ALU_CTRL_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    drain();
    issue("divu", ALU_CTRL_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    drain();
    issue("divu_by0", ALU_CTRL_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
    drain();
    issue("div_minint", ALU_CTRL_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    drain();
    issue("div_neg_by0", ALU_CTRL_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    drain();

    // HI/LO hazard window: old lo=FFFFFFFF, hi=FFFFFFF9 until the done cycle.
    issue("mult_hazard", ALU_CTRL_MULT, 32'h00010000, 32'h00010000, 32'h1, 32'h0);
    for (int i = 1; i <= 33; i++) begin
      if (i == 5)
        probe("add_in_busy", ALU_CTRL_ADD, 32'd2, 32'd3, 1'b1, 32'd5, 0, 0, 0, 1, 0, 0, 0);
      else if (i == 20)
        probe("mfhi_stall", ALU_CTRL_MFHI, 32'h0, 32'h0, 1'b1, 32'hFFFFFFF9, 0, 0, 1, 1, 0, 0, 0);
      else
        probe("mflo_stall", ALU_CTRL_MFLO, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0, 0);
    end
    probe("mflo_done", ALU_CTRL_MFLO, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 0, 0, 1, 32'h1, 32'h0);
    probe("mfhi_after", ALU_CTRL_MFHI, 32'h0, 32'h0, 1'b0, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    drain();

    // Abort an in-flight DIVU at RUN cycle 10; no done may follow.
    drive(ALU_CTRL_DIVU, 32'd100, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    drive(ALU_CTRL_AND, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    probe("abort", ALU_CTRL_AND, 32'h0, 32'h0, 1'b0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    issue("div_after_rst", ALU_CTRL_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
    drain();

    // Back-to-back: second MULTU launched in the first one's done cycle.
    drive(ALU_CTRL_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
    push_md("b2b_first", 32'hFFFFFFFF, 32'hFFFFFFFA);
    @(posedge clk);
    #1;
    drive(ALU_CTRL_AND, 32'd0, 32'd0, 1'b0);
    repeat (33) @(posedge clk);
    #1;
    issue("b2b_second", ALU_CTRL_MULTU, 32'd7, 32'd6, 32'h0, 32'd42);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1);
  end

endmodule
